// File: rtl/gat_debug_pkg.sv
// ============================================================================
// Module      : gat_debug_pkg
// Description : Shared FSM state encoding and read-map addresses for the
//               pipeline debug monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gat_debug_pkg;

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_run  = 2'd1,
        c_st_done = 2'd2
    } state_e;

    localparam logic [7:0] c_addr_id       = 8'h00;
    localparam logic [7:0] c_addr_status   = 8'h01;
    localparam logic [7:0] c_addr_run      = 8'h02;
    localparam logic [7:0] c_addr_cap      = 8'h03;
    localparam logic [7:0] c_addr_hit      = 8'h04;
    localparam logic [7:0] c_addr_vld_base = 8'h10;
    localparam logic [7:0] c_addr_rdy_base = 8'h20;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter with synchronous clear; also
//               presents its value fitted to a 32-bit read word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] o_cnt32
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    generate
        if (CNT_W >= 32) begin : g_trunc
            assign o_cnt32 = r_cnt[31:0];
        end else begin : g_ext
            assign o_cnt32 = {{(32-CNT_W){1'b0}}, r_cnt};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/debug_monitor.sv
// ============================================================================
// Module      : debug_monitor
// Description : Pipeline handshake monitor with run-window timing, probe
//               address trigger/capture and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_monitor
    import gat_debug_pkg::*;
#(
    parameter int          NUM_STAGES = 4,
    parameter int          CNT_W      = 32,
    parameter int          PROBE_W    = 12,
    parameter int          ADDR_W     = 16,
    parameter logic [31:0] ID_VAL     = 32'h0137_1A3C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic [NUM_STAGES-1:0] stage_vld_i,
    input  logic [NUM_STAGES-1:0] stage_rdy_i,
    input  logic                  probe_en_i,
    input  logic [ADDR_W-1:0]     probe_addr_i,
    input  logic [PROBE_W-1:0]    probe_data_i,
    input  logic [ADDR_W-1:0]     trig_addr_i,
    input  logic                  rd_en_i,
    input  logic [7:0]            rd_addr_i,
    output logic [31:0]           rd_data_o,
    output logic                  rd_vld_o,
    output logic [1:0]            state_o
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [NUM_STAGES-1:0] r_vld_seen;
    logic [NUM_STAGES-1:0] r_rdy_seen;
    logic                  r_cap_vld;
    logic [31:0]           r_cap_data;
    logic [31:0]           w_probe32;
    logic                  w_hit;
    logic [31:0]           w_run_cnt;
    logic [31:0]           w_hit_cnt;
    logic [31:0]           w_vld_cnt [NUM_STAGES];
    logic [31:0]           w_rdy_cnt [NUM_STAGES];
    logic [31:0]           w_rd_mux;

    assign w_hit   = probe_en_i && (probe_addr_i == trig_addr_i);
    assign state_o = r_state;

    // clr_i overrides every transition, including the IDLE->RUN start
    always_comb begin
        w_state_nxt = r_state;
        if (clr_i) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: if (stage_vld_i[0])            w_state_nxt = c_st_run;
                c_st_run:  if (stage_rdy_i[NUM_STAGES-1]) w_state_nxt = c_st_done;
                c_st_done: w_state_nxt = c_st_done;
                default:   w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_vld_seen <= '0;
            r_rdy_seen <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clr_i) begin
                r_vld_seen <= '0;
                r_rdy_seen <= '0;
                r_cap_vld  <= 1'b0;
                r_cap_data <= '0;
            end else begin
                r_vld_seen <= r_vld_seen | stage_vld_i;
                r_rdy_seen <= r_rdy_seen | stage_rdy_i;
                if (w_hit && !r_cap_vld) begin
                    r_cap_vld  <= 1'b1;
                    r_cap_data <= w_probe32;
                end
            end
        end
    end

    generate
        if (PROBE_W >= 32) begin : g_probe_trunc
            assign w_probe32 = probe_data_i[31:0];
        end else begin : g_probe_ext
            assign w_probe32 = {{(32-PROBE_W){1'b0}}, probe_data_i};
        end

        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            sat_counter #(.CNT_W(CNT_W)) u_vld_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr_i),
                .inc     (stage_vld_i[k]),
                .o_cnt32 (w_vld_cnt[k])
            );
            sat_counter #(.CNT_W(CNT_W)) u_rdy_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr_i),
                .inc     (stage_rdy_i[k]),
                .o_cnt32 (w_rdy_cnt[k])
            );
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_i),
        .inc     (r_state == c_st_run),
        .o_cnt32 (w_run_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_i),
        .inc     (w_hit),
        .o_cnt32 (w_hit_cnt)
    );

    // Mux only looks at registered state, so a read sees pre-event values
    always_comb begin
        w_rd_mux = '0;
        case (rd_addr_i)
            c_addr_id:     w_rd_mux = ID_VAL;
            c_addr_status: w_rd_mux = 32'({r_cap_vld, r_state, r_vld_seen, r_rdy_seen});
            c_addr_run:    w_rd_mux = w_run_cnt;
            c_addr_cap:    w_rd_mux = r_cap_data;
            c_addr_hit:    w_rd_mux = w_hit_cnt;
            default:       w_rd_mux = '0;
        endcase
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (rd_addr_i == (c_addr_vld_base + 8'(k))) w_rd_mux = w_vld_cnt[k];
            if (rd_addr_i == (c_addr_rdy_base + 8'(k))) w_rd_mux = w_rdy_cnt[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
            rd_vld_o  <= 1'b0;
        end else begin
            rd_vld_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= w_rd_mux;
            end
        end
    end

endmodule

`default_nettype wire
